// File: rtl/gate_pair_sequencer.sv
// gate_pair_sequencer
//
// Applies a single-qubit gate (X, Z, Y or identity) to a state vector of
// 2^NUM_QUBITS complex amplitudes. The amplitudes live in a register file.
// The sequencer walks every amplitude pair (i0, i1) that differs only in
// the target bit. For each pair it spends one FETCH cycle and one WRITE cycle.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   load_valid   amplitude write request (accepted only while idle)
//   load_ready   high when a load is accepted (IDLE only)
//   load_idx     amplitude index to write
//   load_r/i     amplitude value to write (signed)
//   start        one-cycle request to apply a gate
//   gate_op      00=X, 01=Z, 10=Y, 11=identity
//   target       target qubit index
//   busy         high while pairs are being processed
//   done         one-cycle pulse when a gate completes
//   err          sticky flag for an illegal target, cleared by the next legal start
//   rd_idx       readback index
//   rd_r/i       combinational readback of amplitude[rd_idx]

// The amplitude width normally comes from the shared fixed-point header.
// If that header has not been included, the width falls back to 16 bits.
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 16
`endif

module gate_pair_sequencer #(
   parameter int NUM_QUBITS = 3
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            load_valid,
   output logic                            load_ready,
   input  logic [NUM_QUBITS-1:0]           load_idx,
   input  logic signed [`TOTAL_WIDTH-1:0]  load_r,
   input  logic signed [`TOTAL_WIDTH-1:0]  load_i,
   input  logic                            start,
   input  logic [1:0]                      gate_op,
   input  logic [2:0]                      target,
   output logic                            busy,
   output logic                            done,
   output logic                            err,
   input  logic [NUM_QUBITS-1:0]           rd_idx,
   output logic signed [`TOTAL_WIDTH-1:0]  rd_r,
   output logic signed [`TOTAL_WIDTH-1:0]  rd_i
);

   localparam int W     = `TOTAL_WIDTH;
   localparam int DEPTH = 2 ** NUM_QUBITS;
   localparam int KW    = (NUM_QUBITS > 1) ? NUM_QUBITS - 1 : 1;
   localparam logic [KW-1:0] K_LAST = KW'((DEPTH / 2) - 1);
   localparam logic signed [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE, S_FIN} state_t;
   typedef enum logic [1:0] {OP_X = 2'b00, OP_Z = 2'b01, OP_Y = 2'b10, OP_I = 2'b11} op_t;

   state_t state, next_state;
   op_t    op_q;
   logic [2:0]    tgt_q;
   logic [KW-1:0] k;

   logic signed [W-1:0] amp_r [DEPTH];
   logic signed [W-1:0] amp_i [DEPTH];
   logic signed [W-1:0] alpha_r, alpha_i, beta_r, beta_i;
   logic signed [W-1:0] new_a_r, new_a_i, new_b_r, new_b_i;

   logic [NUM_QUBITS-1:0] kx, low_mask, tgt_bit, i0, i1;
   logic start_legal, start_illegal;

   // Negation clamps the most-negative code to the most-positive one.
   // Two's complement would otherwise wrap the result back to itself.
   function automatic logic signed [W-1:0] neg_sat(input logic signed [W-1:0] x);
      return (x == S_MIN) ? S_MAX : -x;
   endfunction

   // Pair addressing. The bits of k below the target stay where they are.
   // The bits at or above the target move up by one position, which leaves
   // a 0 at the target bit. The top bit of kx is always 0, so nothing is
   // lost by the shift.
   always_comb begin
      kx       = NUM_QUBITS'(k);
      tgt_bit  = NUM_QUBITS'(1) << tgt_q;
      low_mask = tgt_bit - NUM_QUBITS'(1);
      i0       = (kx & low_mask) | ((kx & ~low_mask) << 1);
      i1       = i0 | tgt_bit;
   end

   // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      next_state    = state;
      start_legal   = 1'b0;
      start_illegal = 1'b0;
      load_ready    = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      case (state)
         S_IDLE: begin
            load_ready = 1'b1;
            if (start) begin
               if (32'(target) < NUM_QUBITS) begin
                  start_legal = 1'b1;
                  next_state  = S_FETCH;
               end else begin
                  start_illegal = 1'b1;
                  next_state    = S_FIN;
               end
            end
         end
         S_FETCH: begin
            busy       = 1'b1;
            next_state = S_WRITE;
         end
         S_WRITE: begin
            busy       = 1'b1;
            next_state = (k == K_LAST) ? S_FIN : S_FETCH;
         end
         S_FIN: begin
            done       = 1'b1;
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Gate arithmetic on the fetched pair. Identity passes both values through unchanged.
   always_comb begin
      new_a_r = alpha_r;
      new_a_i = alpha_i;
      new_b_r = beta_r;
      new_b_i = beta_i;
      case (op_q)
         OP_X: begin
            new_a_r = beta_r;
            new_a_i = beta_i;
            new_b_r = alpha_r;
            new_b_i = alpha_i;
         end
         OP_Z: begin
            new_b_r = neg_sat(beta_r);
            new_b_i = neg_sat(beta_i);
         end
         OP_Y: begin
            new_a_r = beta_i;
            new_a_i = neg_sat(beta_r);
            new_b_r = neg_sat(alpha_i);
            new_b_i = alpha_r;
         end
         default: ;
      endcase
   end

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the state vector is a small flop array that must read back as zero after reset, so every entry is cleared here.
         for (int n = 0; n < DEPTH; n++) begin
            amp_r[n] <= '0;
            amp_i[n] <= '0;
         end
         alpha_r <= '0;
         alpha_i <= '0;
         beta_r  <= '0;
         beta_i  <= '0;
         k       <= '0;
         op_q    <= OP_X;
         tgt_q   <= '0;
         err     <= 1'b0;
      end else begin
         if (load_valid && load_ready) begin
            amp_r[load_idx] <= load_r;
            amp_i[load_idx] <= load_i;
         end
         if (start_legal) begin
            op_q  <= op_t'(gate_op);
            tgt_q <= target;
            k     <= '0;
            err   <= 1'b0;
         end
         // An illegal target leaves op, target and the state vector untouched.
         if (start_illegal) err <= 1'b1;
         if (state == S_FETCH) begin
            alpha_r <= amp_r[i0];
            alpha_i <= amp_i[i0];
            beta_r  <= amp_r[i1];
            beta_i  <= amp_i[i1];
         end
         if (state == S_WRITE) begin
            amp_r[i0] <= new_a_r;
            amp_i[i0] <= new_a_i;
            amp_r[i1] <= new_b_r;
            amp_i[i1] <= new_b_i;
            if (k != K_LAST) k <= k + KW'(1);
         end
      end
   end

   assign rd_r = amp_r[rd_idx];
   assign rd_i = amp_i[rd_idx];

endmodule

// File: tb/tb_gate_pair_sequencer.sv
// Testbench for gate_pair_sequencer with NUM_QUBITS=3.
// The stimulus process pushes the expected responses into a scoreboard
// queue. There are two kinds of entry: a gate completion, or an idle-state
// snapshot. The monitor process compares at each falling edge where the
// DUT pulses done or a snapshot has been requested. At that point the
// monitor sweeps rd_idx over the whole vector.

`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 16
`endif

module tb_gate_pair_sequencer;

   localparam int NQ = 3;
   localparam int W  = `TOTAL_WIDTH;

   typedef logic [7:0][W-1:0] vec_t;
   typedef enum logic {K_DONE = 1'b0, K_SNAP = 1'b1} kind_t;
   typedef struct packed {
      kind_t       kind;
      logic [31:0] cyc;
      logic        err;
      logic [31:0] busy_cycles;
      vec_t        r;
      vec_t        i;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          load_valid;
   logic          load_ready;
   logic [NQ-1:0] load_idx;
   logic [W-1:0]  load_r, load_i;
   logic          start;
   logic [1:0]    gate_op;
   logic [2:0]    target;
   logic          busy, done, err;
   logic [NQ-1:0] rd_idx = '0;
   logic [W-1:0]  rd_r, rd_i;

   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;
   int   done_cnt = 0;
   int   exp_done = 0;
   int   snap_req = 0;
   int   snap_ack = 0;
   int   busy_run = 0;
   exp_t sb[$];

   gate_pair_sequencer #(.NUM_QUBITS(NQ)) dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_ready(load_ready), .load_idx(load_idx),
      .load_r(load_r), .load_i(load_i),
      .start(start), .gate_op(gate_op), .target(target),
      .busy(busy), .done(done), .err(err),
      .rd_idx(rd_idx), .rd_r(rd_r), .rd_i(rd_i)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Called only by the monitor, which is the single driver of rd_idx.
   task automatic compare_vec(input string tag, input vec_t er, input vec_t ei);
      for (int n = 0; n < 8; n++) begin
         rd_idx = NQ'(n);
         #1;
         check($sformatf("%s amp_r[%0d]", tag, n), 32'(rd_r), 32'(er[n]));
         check($sformatf("%s amp_i[%0d]", tag, n), 32'(rd_i), 32'(ei[n]));
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (busy === 1'b1) busy_run++;
         if (done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
               check("done_without_expectation", 32'(done), 32'd0);
            end else begin
               e = sb.pop_front();
               check("entry_kind_at_done", 32'(K_DONE), 32'(e.kind));
               check("done_cycle", cyc, e.cyc);
               check("err_at_done", 32'(err), 32'(e.err));
               check("busy_cycles", busy_run, e.busy_cycles);
               check("load_ready_in_fin", 32'(load_ready), 32'd0);
               compare_vec("done", e.r, e.i);
            end
            busy_run = 0;
         end else if (snap_req != snap_ack) begin
            snap_ack++;
            if (sb.size() == 0) begin
               check("snapshot_without_entry", snap_req, snap_ack - 1);
            end else begin
               e = sb.pop_front();
               check("entry_kind_at_snap", 32'(K_SNAP), 32'(e.kind));
               check("snap_load_ready", 32'(load_ready), 32'd1);
               check("snap_busy", 32'(busy), 32'd0);
               check("snap_err", 32'(err), 32'(e.err));
               compare_vec("snap", e.r, e.i);
            end
            busy_run = 0;
         end
      end
   end

   // All stimulus tasks begin and end 1 time unit after a rising edge.
   task automatic load_one(input int idx, input logic [W-1:0] r, input logic [W-1:0] i);
      load_valid = 1'b1;
      load_idx   = NQ'(idx);
      load_r     = r;
      load_i     = i;
      @(posedge clk); #1;
      load_valid = 1'b0;
   endtask

   task automatic load_all(input vec_t r, input vec_t i);
      for (int n = 0; n < 8; n++) load_one(n, r[n], i[n]);
   endtask

   task automatic snap(input logic exp_err, input vec_t er, input vec_t ei);
      exp_t e;
      e.kind = K_SNAP;
      e.cyc = '0;
      e.err = exp_err;
      e.busy_cycles = '0;
      e.r = er;
      e.i = ei;
      sb.push_back(e);
      snap_req++;
      @(posedge clk); #1;
   endtask

   task automatic start_gate(input logic [1:0] op, input logic [2:0] tgt, input int lat,
                             input int bcyc, input logic exp_err, input vec_t er, input vec_t ei);
      exp_t e;
      e.kind = K_DONE;
      e.cyc = 32'(cyc + lat);
      e.err = exp_err;
      e.busy_cycles = 32'(bcyc);
      e.r = er;
      e.i = ei;
      sb.push_back(e);
      exp_done++;
      start   = 1'b1;
      gate_op = op;
      target  = tgt;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done();
      int waited = 0;
      while (done_cnt < exp_done && waited < 40) begin
         @(posedge clk); #1;
         waited++;
      end
      check("done_within_budget", done_cnt, exp_done);
   endtask

   initial begin : stimulus
      vec_t lr, li, er, ei, zero;
      zero       = '0;
      rst        = 1'b1;
      load_valid = 1'b0;
      load_idx   = '0;
      load_r     = '0;
      load_i     = '0;
      start      = 1'b0;
      gate_op    = 2'b00;
      target     = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state.
      snap(1'b0, zero, zero);

      // X on target 0 moves the single nonzero amplitude from index 0 to index 1.
      lr = '0; li = '0; lr[0] = 16'h0100;
      load_all(lr, li);
      er = '0; ei = '0; er[1] = 16'h0100;
      start_gate(2'b00, 3'd2 - 3'd2, 9, 8, 1'b0, er, ei);
      wait_done();

      // X on target 2 swaps the lower and upper halves of the vector.
      for (int n = 0; n < 8; n++) begin
         lr[n] = 16'(n);
         li[n] = 16'(-n);
         er[n] = 16'(n ^ 4);
         ei[n] = 16'(-(n ^ 4));
      end
      load_all(lr, li);
      start_gate(2'b00, 3'd2, 9, 8, 1'b0, er, ei);
      wait_done();

      // Y on target 1: amp[3]=(5,7) gives amp[1]=(7,-5), and amp[3] becomes 0.
      lr = '0; li = '0; lr[3] = 16'd5; li[3] = 16'd7;
      load_all(lr, li);
      er = '0; ei = '0; er[1] = 16'd7; ei[1] = 16'hFFFB;
      start_gate(2'b10, 3'd1, 9, 8, 1'b0, er, ei);
      wait_done();

      // Z on target 0 negates the odd amplitudes and saturates the most-negative code.
      lr = '0; li = '0;
      lr[0] = 16'h8000; li[0] = 16'h0001;
      lr[1] = 16'h8000; li[1] = 16'h0000;
      lr[3] = 16'h1234; li[3] = 16'h8000;
      lr[6] = 16'h0003; li[6] = 16'hFFFD;
      lr[7] = 16'hFFFE; li[7] = 16'h7FFF;
      load_all(lr, li);
      er = lr; ei = li;
      er[1] = 16'h7FFF; ei[1] = 16'h0000;
      er[3] = 16'hEDCC; ei[3] = 16'h7FFF;
      er[7] = 16'h0002; ei[7] = 16'h8001;
      start_gate(2'b01, 3'd0, 9, 8, 1'b0, er, ei);
      wait_done();

      // Illegal target: err is set, done comes one cycle later, and the vector is untouched.
      start_gate(2'b00, 3'd5, 1, 0, 1'b1, er, ei);
      wait_done();
      snap(1'b1, er, ei);

      // A legal identity gate clears err. A start and a load issued
      // mid-operation are both dropped.
      start_gate(2'b11, 3'd2, 9, 8, 1'b0, er, ei);
      repeat (2) begin @(posedge clk); #1; end
      start      = 1'b1;
      gate_op    = 2'b00;
      target     = 3'd0;
      load_valid = 1'b1;
      load_idx   = '0;
      load_r     = 16'h5555;
      load_i     = 16'h5555;
      @(posedge clk); #1;
      start      = 1'b0;
      load_valid = 1'b0;
      wait_done();

      // A load and a start in the same idle cycle: the load lands first, then X on target 0.
      load_valid = 1'b1;
      load_idx   = '0;
      load_r     = 16'h0040;
      load_i     = 16'h0000;
      lr = er; li = ei;
      er[0] = 16'h7FFF; ei[0] = 16'h0000;
      er[1] = 16'h0040; ei[1] = 16'h0000;
      er[2] = 16'hEDCC; ei[2] = 16'h7FFF;
      er[3] = 16'h0000; ei[3] = 16'h0000;
      er[6] = lr[7];    ei[6] = li[7];
      er[7] = lr[6];    ei[7] = li[6];
      start_gate(2'b00, 3'd0, 9, 8, 1'b0, er, ei);
      load_valid = 1'b0;
      wait_done();

      // Reset at cycle 4 of a gate aborts it with no done pulse. In the next
      // cycle the vector reads all zero and load_ready is high.
      start   = 1'b1;
      gate_op = 2'b00;
      target  = 3'd0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      snap(1'b0, zero, zero);
      repeat (20) begin @(posedge clk); #1; end
      check("no_done_after_reset", done_cnt, exp_done);
      check("scoreboard_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gate_pair_sequencer.md
GATE_PAIR_SEQUENCER -- requirements
Module: gate_pair_sequencer

Interface
REQ-001 SHALL have parameter NUM_QUBITS, default 3, giving the number of qubits; the state holds 2^NUM_QUBITS complex amplitudes.
REQ-002 SHALL use amplitude width `TOTAL_WIDTH (signed, from fixed_point_params.vh) for every real and imaginary port and register.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- load_valid  in  1  amplitude write request
- load_ready  out  1  high when a load is accepted (IDLE only)
- load_idx  in  NUM_QUBITS  amplitude index to write
- load_r, load_i  in  `TOTAL_WIDTH  amplitude value (signed)
- start  in  1  one-cycle request to apply a gate
- gate_op  in  2  00=X, 01=Z, 10=Y, 11=identity
- target  in  3  target qubit index
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when a gate completes
- err  out  1  sticky until next accepted start; set for an illegal target
- rd_idx  in  NUM_QUBITS  readback index
- rd_r, rd_i  out  `TOTAL_WIDTH  combinational readback of amplitude[rd_idx]

Function
REQ-004 SHALL hold the state vector in registers amp_r/amp_i[0..2^NUM_QUBITS-1].
REQ-005 SHALL write load_r/load_i into amplitude[load_idx] on the clock edge where load_valid && load_ready; load_ready = (state==IDLE).
REQ-006 SHALL have FSM states IDLE, FETCH, WRITE, FIN; FSM encoding is free.
REQ-007 IDLE: start=1 with target<NUM_QUBITS -> latch gate_op and target, clear pair counter k, clear err, go to FETCH; start with target>=NUM_QUBITS -> set err, go to FIN, leave the state untouched.
REQ-008 SHALL, for pair counter k (NUM_QUBITS-1 bits), compute i0 = k with a 0 inserted at bit position target, and i1 = i0 | (1<<target).
REQ-009 FETCH: register alpha=amp[i0] and beta=amp[i1] into pipeline registers, then go to WRITE.
REQ-010 WRITE: write the gate results to amp[i0] and amp[i1]; if k==2^(NUM_QUBITS-1)-1 go to FIN, else k+=1 and go to FETCH.
REQ-011 Gate math, with a'=new amp[i0] and b'=new amp[i1]:
- X: a'=b, b'=a.
- Z: a'=a, b'=-b.
- Y: a'=(beta_i, -beta_r), b'=(-alpha_i, alpha_r).
- identity: unchanged.
REQ-012 Negation SHALL saturate: the most-negative value maps to the most-positive value; no other rounding or width growth.
REQ-013 FIN: assert done for exactly one cycle, then return to IDLE; busy=0 in FIN and IDLE.
REQ-014 Latency SHALL be start accepted at cycle 0 -> done at cycle 2*2^(NUM_QUBITS-1)+1 (9 for NUM_QUBITS=3); an illegal target gives done at cycle 1.
REQ-015 start while busy SHALL be ignored; start and load_valid in the same IDLE cycle: load is written and start is also accepted.
REQ-016 load_valid outside IDLE SHALL be dropped, with no state change.
REQ-017 Readback SHALL reflect register contents, including mid-operation partial results.

Reset
REQ-018 When rst=1 at a clock edge, the block SHALL go to IDLE, clear all amplitudes, pipeline registers, k, latched op/target, busy, done and err to 0; load_ready=1 in the cycle after.
REQ-019 Reset mid-operation SHALL abort the gate with no done pulse; rst has priority over start and load.

Verification
REQ-020 Bench SHALL cover the following directed scenarios:
- Load amp[0]=(0x100,0) and all others 0, then X on target 0 -> done at cycle 9, amp[1]=(0x100,0), amp[0]=0.
- Load amp[k]=(k,-k) for k=0..7, then X on target 2 -> amp[0..3] and amp[4..7] swapped.
- Load amp[3]=(5,7), then Y on target 1 -> amp[1]=(7,-5), amp[3]=(0,0); amp[1] was (0,0) before.
- Load amp[1]=(most-negative,0), then Z on target 0 -> amp[1]=(most-positive,0) (saturation).
- target=5 with NUM_QUBITS=3 -> err=1, done at cycle 1, state unchanged; a second start during busy is ignored.
- rst asserted at cycle 4 of a gate -> no done pulse, all amplitudes read 0, load_ready=1 next cycle.
